// File: rtl/ramp_pkg.sv
// Shared types and default parameter values for the staged ramp start controller.
package ramp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RUN       = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } ramp_state_e;

    localparam int unsigned CLK_DIV_DEF    = 4;
    localparam int unsigned N_STAGES_DEF   = 3;
    localparam int unsigned DWELL_FAST_DEF = 1;
    localparam int unsigned DWELL_SLOW_DEF = 4;

endpackage

// File: rtl/ramp_tick_gen.sv
// Dwell prescaler: down-counter that emits a one-cycle tick every CLK_DIV enabled clocks.
module ramp_tick_gen
    import ramp_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // Clear reloads the full period so a new stage always gets CLK_DIV cycles per tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= RELOAD;
        end else if (ena) begin
            cnt <= (cnt == '0) ? RELOAD : cnt - CW'(1);
        end
    end

    assign tick = ena && (cnt == '0);

endmodule

// File: rtl/ramp_start_ctrl.sv
// Staged ramp-up / ramp-down start sequencer with per-stage dwell timing.
// Optional RAMP_PWM_EN adds a pwm output whose duty cycle is level/N_STAGES.
//
// state        | meaning
// -------------+-------------------------------------------------
// ST_IDLE      | level 0, waiting for go
// ST_RAMP_UP   | stepping level up once per dwell
// ST_RUN       | level N_STAGES, holding while go stays high
// ST_RAMP_DOWN | stepping level down once per dwell
module ramp_start_ctrl
    import ramp_pkg::*;
#(
    parameter int unsigned CLK_DIV    = CLK_DIV_DEF,
    parameter int unsigned N_STAGES   = N_STAGES_DEF,
    parameter int unsigned DWELL_FAST = DWELL_FAST_DEF,
    parameter int unsigned DWELL_SLOW = DWELL_SLOW_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic                          go,
    input  logic                          fast,
    input  logic                          estop,
    output logic [N_STAGES-1:0]           stage,
    output logic [$clog2(N_STAGES+1)-1:0] level,
    output logic                          busy,
    output logic                          at_speed
`ifdef RAMP_PWM_EN
    ,
    output logic                          pwm
`endif
);

    localparam int unsigned LW   = $clog2(N_STAGES + 1);
    localparam int unsigned DMAX = (DWELL_FAST > DWELL_SLOW) ? DWELL_FAST : DWELL_SLOW;
    localparam int unsigned DW   = (DMAX < 2) ? 1 : $clog2(DMAX);

    localparam logic [LW-1:0] LVL_MAX   = LW'(N_STAGES);
    localparam logic [DW-1:0] LOAD_FAST = DW'(DWELL_FAST - 1);
    localparam logic [DW-1:0] LOAD_SLOW = DW'(DWELL_SLOW - 1);

    ramp_state_e          state_q, state_d;
    logic [LW-1:0]        level_q, level_d;
    logic [DW-1:0]        dwell_q, dwell_d;
    logic                 fast_q, fast_d;
    logic [N_STAGES-1:0]  stage_d;
    logic                 tick;
    logic                 expire;
    logic                 clr;

    ramp_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .clr   (clr),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        fast_d  = fast_q;
        expire  = tick && (dwell_q == '0);

        if (estop) begin
            state_d = ST_IDLE;
            level_d = '0;
        end else if (ena) begin
            case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        state_d = ST_RAMP_UP;
                        level_d = LW'(1);
                        fast_d  = fast;
                    end
                end
                ST_RAMP_UP: begin
                    if (!go) begin
                        state_d = ST_RAMP_DOWN;
                    end else if (expire) begin
                        if (level_q >= LVL_MAX - LW'(1)) begin
                            level_d = LVL_MAX;
                            state_d = ST_RUN;
                        end else begin
                            level_d = level_q + LW'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (!go) begin
                        state_d = ST_RAMP_DOWN;
                    end
                end
                ST_RAMP_DOWN: begin
                    if (go) begin
                        state_d = ST_RAMP_UP;
                    end else if (expire) begin
                        if (level_q <= LW'(1)) begin
                            level_d = '0;
                            state_d = ST_IDLE;
                        end else begin
                            level_d = level_q - LW'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    level_d = '0;
                end
            endcase
        end

        // Any level or state change restarts both the prescaler and the dwell count.
        clr = estop || (state_d != state_q) || (level_d != level_q);

        if (clr) begin
            dwell_d = fast_d ? LOAD_FAST : LOAD_SLOW;
        end else if (tick && (dwell_q != '0)) begin
            dwell_d = dwell_q - DW'(1);
        end else begin
            dwell_d = dwell_q;
        end

        stage_d = '0;
        for (int unsigned k = 0; k < N_STAGES; k++) begin
            stage_d[k] = (32'(level_d) > k);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            level_q  <= '0;
            dwell_q  <= '0;
            fast_q   <= 1'b0;
            stage    <= '0;
            busy     <= 1'b0;
            at_speed <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            dwell_q  <= dwell_d;
            fast_q   <= fast_d;
            stage    <= stage_d;
            busy     <= (state_d == ST_RAMP_UP) || (state_d == ST_RAMP_DOWN);
            at_speed <= (state_d == ST_RUN);
        end
    end

    assign level = level_q;

`ifdef RAMP_PWM_EN
    localparam int unsigned PW = $clog2(N_STAGES);

    logic [PW-1:0] pwm_cnt;

    // Period of N_STAGES clocks; high for the first level_d slots of each period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            pwm     <= 1'b0;
        end else if (ena) begin
            pwm_cnt <= (pwm_cnt == PW'(N_STAGES - 1)) ? '0 : pwm_cnt + PW'(1);
            pwm     <= (32'(pwm_cnt) < 32'(level_d));
        end
    end
`endif

endmodule

// File: tb/tb_ramp_start_ctrl.sv
// Directed self-checking bench for ramp_start_ctrl (CLK_DIV=4, N_STAGES=3, DWELL_FAST=1, DWELL_SLOW=2).
module tb_ramp_start_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       go;
    logic       fast;
    logic       estop;
    logic [2:0] stage;
    logic [1:0] level;
    logic       busy;
    logic       at_speed;
`ifdef RAMP_PWM_EN
    logic       pwm;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ramp_start_ctrl #(
        .CLK_DIV    (4),
        .N_STAGES   (3),
        .DWELL_FAST (1),
        .DWELL_SLOW (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .go       (go),
        .fast     (fast),
        .estop    (estop),
        .stage    (stage),
        .level    (level),
        .busy     (busy),
        .at_speed (at_speed)
`ifdef RAMP_PWM_EN
        ,
        .pwm      (pwm)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic [1:0] lvl, input logic [2:0] stg,
                           input logic bsy, input logic spd);
        chk({tag, ".level"},    32'(level),    32'(lvl));
        chk({tag, ".stage"},    32'(stage),    32'(stg));
        chk({tag, ".busy"},     32'(busy),     32'(bsy));
        chk({tag, ".at_speed"}, 32'(at_speed), 32'(spd));
    endtask

    initial begin
        rst_n = 1'b0;
        ena   = 1'b1;
        go    = 1'b0;
        fast  = 1'b0;
        estop = 1'b0;
        wait_neg(3);
        chk_out("reset", 2'd0, 3'b000, 1'b0, 1'b0);
        rst_n = 1'b1;
        wait_neg(2);
        chk_out("idle", 2'd0, 3'b000, 1'b0, 1'b0);

        // fast ramp up, hold in RUN, then fast ramp down
        fast = 1'b1;
        go   = 1'b1;
        wait_neg(1);  chk_out("fast_l1", 2'd1, 3'b001, 1'b1, 1'b0);
        wait_neg(3);  chk_out("fast_l1_end", 2'd1, 3'b001, 1'b1, 1'b0);
        wait_neg(1);  chk_out("fast_l2", 2'd2, 3'b011, 1'b1, 1'b0);
        wait_neg(4);  chk_out("fast_run", 2'd3, 3'b111, 1'b0, 1'b1);
        wait_neg(6);  chk_out("run_hold", 2'd3, 3'b111, 1'b0, 1'b1);
        go = 1'b0;
        wait_neg(1);  chk_out("fdown_enter", 2'd3, 3'b111, 1'b1, 1'b0);
        wait_neg(4);  chk_out("fdown_l2", 2'd2, 3'b011, 1'b1, 1'b0);
        wait_neg(4);  chk_out("fdown_l1", 2'd1, 3'b001, 1'b1, 1'b0);
        wait_neg(4);  chk_out("fdown_idle", 2'd0, 3'b000, 1'b0, 1'b0);
        wait_neg(5);  chk_out("idle_hold", 2'd0, 3'b000, 1'b0, 1'b0);

        // slow ramp; fast toggled in RUN must not shorten the ramp down
        fast = 1'b0;
        go   = 1'b1;
        wait_neg(1);  chk_out("slow_l1", 2'd1, 3'b001, 1'b1, 1'b0);
        wait_neg(7);  chk_out("slow_l1_end", 2'd1, 3'b001, 1'b1, 1'b0);
        wait_neg(1);  chk_out("slow_l2", 2'd2, 3'b011, 1'b1, 1'b0);
        wait_neg(8);  chk_out("slow_run", 2'd3, 3'b111, 1'b0, 1'b1);
        go   = 1'b0;
        fast = 1'b1;
        wait_neg(1);  chk_out("sdown_enter", 2'd3, 3'b111, 1'b1, 1'b0);
        wait_neg(7);  chk_out("sdown_l3_end", 2'd3, 3'b111, 1'b1, 1'b0);
        wait_neg(1);  chk_out("sdown_l2", 2'd2, 3'b011, 1'b1, 1'b0);
        wait_neg(8);  chk_out("sdown_l1", 2'd1, 3'b001, 1'b1, 1'b0);
        wait_neg(8);  chk_out("sdown_idle", 2'd0, 3'b000, 1'b0, 1'b0);

        // reversal during ramp up and again during ramp down
        go = 1'b1;
        wait_neg(1);  chk_out("rev_l1", 2'd1, 3'b001, 1'b1, 1'b0);
        wait_neg(4);  chk_out("rev_l2", 2'd2, 3'b011, 1'b1, 1'b0);
        go = 1'b0;
        wait_neg(1);  chk_out("rev_down", 2'd2, 3'b011, 1'b1, 1'b0);
        wait_neg(3);  chk_out("rev_down_end", 2'd2, 3'b011, 1'b1, 1'b0);
        wait_neg(1);  chk_out("rev_down_l1", 2'd1, 3'b001, 1'b1, 1'b0);
        go = 1'b1;
        wait_neg(1);  chk_out("rev_up", 2'd1, 3'b001, 1'b1, 1'b0);
        wait_neg(4);  chk_out("rev_up_l2", 2'd2, 3'b011, 1'b1, 1'b0);
        wait_neg(4);  chk_out("rev_run", 2'd3, 3'b111, 1'b0, 1'b1);

        // estop in RUN, held with go high
        estop = 1'b1;
        wait_neg(1);  chk_out("estop", 2'd0, 3'b000, 1'b0, 1'b0);
        wait_neg(5);  chk_out("estop_hold", 2'd0, 3'b000, 1'b0, 1'b0);
        estop = 1'b0;
        wait_neg(1);  chk_out("estop_rel", 2'd1, 3'b001, 1'b1, 1'b0);

        // ena low mid-stage: stage finishes after the remaining enabled cycles only
        wait_neg(2);
        ena = 1'b0;
        wait_neg(10); chk_out("frozen", 2'd1, 3'b001, 1'b1, 1'b0);
        ena = 1'b1;
        wait_neg(1);  chk_out("thaw_l1", 2'd1, 3'b001, 1'b1, 1'b0);
        wait_neg(1);  chk_out("thaw_l2", 2'd2, 3'b011, 1'b1, 1'b0);

        // estop still acts while ena is low; nothing else moves
        ena   = 1'b0;
        estop = 1'b1;
        wait_neg(1);  chk_out("estop_noena", 2'd0, 3'b000, 1'b0, 1'b0);
        estop = 1'b0;
        wait_neg(2);  chk_out("noena_idle", 2'd0, 3'b000, 1'b0, 1'b0);
        ena = 1'b1;
        wait_neg(1);  chk_out("ena_restart", 2'd1, 3'b001, 1'b1, 1'b0);

        // asynchronous reset mid-ramp, go still high at release
        wait_neg(4);  chk_out("pre_rst", 2'd2, 3'b011, 1'b1, 1'b0);
        #1 rst_n = 1'b0;
        #1 chk_out("async_rst", 2'd0, 3'b000, 1'b0, 1'b0);
        wait_neg(2);
        rst_n = 1'b1;
        wait_neg(1);  chk_out("rst_restart", 2'd1, 3'b001, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ramp_start_ctrl.md
RAMP_START_CTRL -- requirements
Module: ramp_start_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 4, clk cycles per dwell tick (>=2).
REQ-002 Parameter N_STAGES, default 3, number of ramp stages (2..8).
REQ-003 Parameter DWELL_FAST, default 1, ticks spent per stage in fast mode (>=1).
REQ-004 Parameter DWELL_SLOW, default 4, ticks spent per stage in slow mode (>=1).
REQ-005 clk  input  1  single system clock, rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 ena  input  1  global enable; 0 freezes all state.
REQ-008 go  input  1  level; 1 requests ramp up / run, 0 requests ramp down.
REQ-009 fast  input  1  mode select; 1 = DWELL_FAST, 0 = DWELL_SLOW; latched on leaving IDLE.
REQ-010 estop  input  1  emergency stop; highest priority.
REQ-011 stage  output  N_STAGES  thermometer code; bit k set when level > k.
REQ-012 level  output  clog2(N_STAGES+1)  current stage number 0..N_STAGES.
REQ-013 busy  output  1  high in RAMP_UP or RAMP_DOWN.
REQ-014 at_speed  output  1  high in RUN only.

Function
REQ-015 FSM states: IDLE, RAMP_UP, RUN, RAMP_DOWN; all outputs registered.
REQ-016 Dwell expiry = tick count reaches latched dwell value; tick = CLK_DIV clk cycles with ena high.
REQ-017 Prescaler and dwell counters clear on every level or state change, so each stage lasts exactly DWELL*CLK_DIV enabled cycles.
REQ-018 IDLE, go=1: next edge -> RAMP_UP, level=1, mode latched.
REQ-019 RAMP_UP, dwell expiry: level+1; if new level = N_STAGES, state RUN on same edge.
REQ-020 RUN, go=0: next edge -> RAMP_DOWN, level unchanged.
REQ-021 RAMP_DOWN, dwell expiry: level-1; if new level = 0, state IDLE on same edge.
REQ-022 RAMP_UP with go=0: next edge -> RAMP_DOWN from current level, counters cleared.
REQ-023 RAMP_DOWN with go=1: next edge -> RAMP_UP from current level, counters cleared; mode not re-latched.
REQ-024 estop=1 in any state: next edge IDLE, level 0, counters cleared; IDLE held while estop=1 regardless of go.
REQ-025 ena=0: state, level, counters and outputs hold; estop still acts.
REQ-026 fast changes outside IDLE have no effect until next IDLE exit.
REQ-027 level never exceeds N_STAGES nor underflows below 0.

Reset
REQ-028 rst_n low: state IDLE, level 0, stage all-zero, busy 0, at_speed 0, counters 0, latched mode slow.
REQ-029 Reset release mid-ramp resumes from IDLE; go high at release starts a fresh ramp.

Configuration
REQ-030 Macro RAMP_PWM_EN defined: extra output pwm (1 bit), period N_STAGES clk cycles, high for level cycles per period (level 0 -> constant 0, N_STAGES -> constant 1), reset 0, frozen when ena=0.
REQ-031 RAMP_PWM_EN undefined: no pwm port and no PWM logic.

Structure
REQ-032 Package ramp_pkg holds state enum type and encodings, and the default parameter constants.
REQ-033 Sub-module ramp_tick_gen (CLK_DIV counter with ena and synchronous clear, one-cycle tick output); the FSM stays in ramp_start_ctrl.

Verification (CLK_DIV=4, N_STAGES=3, DWELL_FAST=1, DWELL_SLOW=2)
REQ-034 Fast ramp: fast=1, go=1 at edge 0 -> level 1 edge 1, 2 edge 5, 3 edge 9 with at_speed=1, stage=3'b111.
REQ-035 Slow ramp then stop: fast=0, go=1 -> level steps every 8 cycles; in RUN go=0 -> busy=1, level 3->2->1->0 every 8 cycles, IDLE with stage=0.
REQ-036 Reversal: go=0 at level 2 during RAMP_UP -> RAMP_DOWN next edge, level 1 after 4 cycles (fast); go=1 again -> RAMP_UP, level 2 after 4 more cycles.
REQ-037 estop in RUN at level 3 -> next edge level 0, IDLE, busy=0, at_speed=0; go held high stays IDLE until estop=0.
REQ-038 ena=0 for 10 cycles mid-stage -> level and counters frozen; stage completes after remaining enabled cycles only.
REQ-039 RAMP_PWM_EN: level 2 -> pwm pattern 1,1,0 repeating; level 0 -> constant 0; rst_n low mid-ramp -> all outputs 0 immediately.
